chunked_subtractor: RTL and testbench

- Multi-cycle subtractor computing _a_in - _b_in - _b_in_borrow over BITS, processing CHUNK bits per clock with a registered borrow between slices.
- Counterpart to the combinational ripple adder in the arithmetic library.
- Intended for wide datapaths where a full-width borrow chain would not close timing.
- Sits between an operand producer and a result consumer; both sides use valid/ready handshakes.

---
 rtl/chunked_subtractor.sv | 165 ++++++++++++++++
 tb/tb_chunked_subtractor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_subtractor.sv
// chunked_subtractor
//   Multi-cycle subtractor: d = a - b - borrow_in over BITS bits, computed
//   CHUNK bits per clock with the borrow carried between slices in a register.
//   The borrow chain is continuous across slices, so the result is identical
//   to a single BITS-wide subtraction (modulo 2^BITS).
//
// Handshakes (both sides): a transfer happens on a rising _clk edge where
//   valid & ready are both 1. The producer keeps operands stable while
//   _in_valid=1 and _in_ready=0. _out_valid stays high and _d_out/_b_out/_v_out
//   stay stable until _out_ready is seen. Neither ready nor valid depends
//   combinationally on the opposite side's signal.
//
// Ports:
//   _clk, _rst       clock (rising edge), asynchronous active-high reset
//   _in_valid/_in_ready, _a_in, _b_in, _b_in_borrow   operand side
//   _out_valid/_out_ready, _d_out, _b_out, _v_out     result side
//     _b_out : 1 iff unsigned a < b + borrow_in
//     _v_out : signed two's-complement overflow
//   _dbg_state       current FSM state (0=IDLE, 1=RUN, 2=DONE)

module chunked_subtractor #(
  parameter int BITS  = 32,
  parameter int CHUNK = 8
) (
  input  logic            _clk,
  input  logic            _rst,
  input  logic            _in_valid,
  output logic            _in_ready,
  input  logic [BITS-1:0] _a_in,
  input  logic [BITS-1:0] _b_in,
  input  logic            _b_in_borrow,
  output logic            _out_valid,
  input  logic            _out_ready,
  output logic [BITS-1:0] _d_out,
  output logic            _b_out,
  output logic            _v_out,
  output logic [1:0]      _dbg_state
);

  localparam int NCHUNK = BITS / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (BITS % CHUNK) != 0) begin : g_bad_chunk
      $error("chunked_subtractor: BITS must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic [BITS-1:0] dif_q, dif_d;
  logic            borrow_q, borrow_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            bout_q, bout_d;
  logic            vout_q, vout_d;

  logic [CHUNK-1:0] a_slice, b_slice, diff_slice;
  logic             slice_borrow;

  // Select the current slice with constant part-selects so every mux leg is static.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_slice = a_q[k*CHUNK +: CHUNK];
        b_slice = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // CHUNK-bit ripple-borrow chain in generate/propagate form:
  //   generate  : a=0, b=1 always borrows
  //   propagate : a==b passes the incoming borrow through
  always_comb begin
    logic bc;
    bc         = borrow_q;
    diff_slice = '0;
    for (int i = 0; i < CHUNK; i++) begin
      diff_slice[i] = a_slice[i] ^ b_slice[i] ^ bc;
      bc = (~a_slice[i] & b_slice[i]) | (~(a_slice[i] ^ b_slice[i]) & bc);
    end
    slice_borrow = bc;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    dif_d    = dif_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    bout_d   = bout_q;
    vout_d   = vout_q;
    case (state_q)
      S_IDLE: begin
        if (_in_valid) begin
          a_d      = _a_in;
          b_d      = _b_in;
          borrow_d = _b_in_borrow;
          idx_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IDXW'(k)) dif_d[k*CHUNK +: CHUNK] = diff_slice;
        end
        borrow_d = slice_borrow;
        if (idx_q == LAST_IDX) begin
          // The last slice holds the sign bit, so diff_slice[CHUNK-1] is diff[BITS-1].
          bout_d  = slice_borrow;
          vout_d  = (a_q[BITS-1] != b_q[BITS-1]) & (diff_slice[CHUNK-1] != a_q[BITS-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge _clk or posedge _rst) begin
    if (_rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      dif_q    <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      bout_q   <= 1'b0;
      vout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dif_q    <= dif_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      bout_q   <= bout_d;
      vout_q   <= vout_d;
    end
  end

  // Handshake outputs come straight from the state register.
  assign _in_ready  = (state_q == S_IDLE);
  assign _out_valid = (state_q == S_DONE);
  assign _d_out     = dif_q;
  assign _b_out     = bout_q;
  assign _v_out     = vout_q;
  assign _dbg_state = state_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
module tb_chunked_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Three instances: index 0 -> CHUNK=1, 1 -> CHUNK=8, 2 -> CHUNK=32 (BITS=32).
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] a         [3];
  logic [31:0] b         [3];
  logic        bin       [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] d_out     [3];
  logic        b_out     [3];
  logic        v_out     [3];
  logic [1:0]  dbg       [3];

  chunked_subtractor #(.BITS(32), .CHUNK(1)) u_c1 (
    ._clk(clk), ._rst(rst), ._in_valid(in_valid[0]), ._in_ready(in_ready[0]),
    ._a_in(a[0]), ._b_in(b[0]), ._b_in_borrow(bin[0]), ._out_valid(out_valid[0]),
    ._out_ready(out_ready[0]), ._d_out(d_out[0]), ._b_out(b_out[0]), ._v_out(v_out[0]),
    ._dbg_state(dbg[0]));

  chunked_subtractor #(.BITS(32), .CHUNK(8)) u_c8 (
    ._clk(clk), ._rst(rst), ._in_valid(in_valid[1]), ._in_ready(in_ready[1]),
    ._a_in(a[1]), ._b_in(b[1]), ._b_in_borrow(bin[1]), ._out_valid(out_valid[1]),
    ._out_ready(out_ready[1]), ._d_out(d_out[1]), ._b_out(b_out[1]), ._v_out(v_out[1]),
    ._dbg_state(dbg[1]));

  chunked_subtractor #(.BITS(32), .CHUNK(32)) u_c32 (
    ._clk(clk), ._rst(rst), ._in_valid(in_valid[2]), ._in_ready(in_ready[2]),
    ._a_in(a[2]), ._b_in(b[2]), ._b_in_borrow(bin[2]), ._out_valid(out_valid[2]),
    ._out_ready(out_ready[2]), ._d_out(d_out[2]), ._b_out(b_out[2]), ._v_out(v_out[2]),
    ._dbg_state(dbg[2]));

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [33:0] exp_q[$];   // {v_out, b_out, d_out}
  logic [33:0] last_exp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nchunk(input int u);
    return (u == 0) ? 32 : ((u == 1) ? 4 : 1);
  endfunction

  // Reference: plain wide integer arithmetic, unsigned for borrow, signed for overflow.
  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic bi);
    longint ua, ub, bl, ud, sa, sb, sd;
    logic   bo, ov;
    ua = longint'({32'b0, av});
    ub = longint'({32'b0, bv});
    bl = longint'({63'b0, bi});
    ud = ua - ub - bl;
    bo = (ud < 0);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    sd = sa - sb - bl;
    ov = (sd < -64'sd2147483648) || (sd > 64'sd2147483647);
    return {ov, bo, ud[31:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Present operands in IDLE, return at the negedge after the accept edge.
  task automatic start(input int u, input logic [31:0] av, input logic [31:0] bv,
                       input logic bi, input logic [33:0] e);
    @(negedge clk);
    check_eq($sformatf("u%0d_in_ready_idle", u), 64'(in_ready[u]), 64'd1);
    exp_q.push_back(e);
    in_valid[u] = 1'b1;
    a[u] = av;
    b[u] = bv;
    bin[u] = bi;
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0;
    a[u] = $urandom;
    b[u] = $urandom;
    bin[u] = 1'($urandom_range(0, 1));
  endtask

  // Called at the negedge after the accept edge; counts edges until out_valid.
  task automatic wait_valid(input int u);
    int lat;
    lat = 0;
    while (!out_valid[u] && lat < 100) begin
      check_eq($sformatf("u%0d_in_ready_busy", u), 64'(in_ready[u]), 64'd0);
      @(negedge clk);
      lat++;
    end
    check_eq($sformatf("u%0d_latency", u), 64'(lat), 64'(nchunk(u)));
  endtask

  task automatic check_result(input int u);
    if (exp_q.size() == 0) begin
      check_eq($sformatf("u%0d_queue_empty", u), 64'd1, 64'd0);
    end else begin
      last_exp = exp_q.pop_front();
      check_eq($sformatf("u%0d_d_out", u), 64'(d_out[u]), 64'(last_exp[31:0]));
      check_eq($sformatf("u%0d_b_out", u), 64'(b_out[u]), 64'(last_exp[32]));
      check_eq($sformatf("u%0d_v_out", u), 64'(v_out[u]), 64'(last_exp[33]));
    end
  endtask

  // Pulse out_ready for one edge; outputs must keep the last result afterwards.
  task automatic handoff(input int u);
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    check_eq($sformatf("u%0d_valid_drop", u), 64'(out_valid[u]), 64'd0);
    check_eq($sformatf("u%0d_ready_back", u), 64'(in_ready[u]), 64'd1);
    check_eq($sformatf("u%0d_hold_d", u), 64'(d_out[u]), 64'(last_exp[31:0]));
  endtask

  task automatic do_op(input int u, input logic [31:0] av, input logic [31:0] bv,
                       input logic bi, input logic [33:0] e, input int stall);
    start(u, av, bv, bi, e);
    wait_valid(u);
    check_result(u);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq($sformatf("u%0d_stall_valid", u), 64'(out_valid[u]), 64'd1);
      check_eq($sformatf("u%0d_stall_d", u), 64'(d_out[u]), 64'(last_exp[31:0]));
    end
    handoff(u);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] av, bv;
    logic        bi;
    int          u;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      a[i] = '0; b[i] = '0; bin[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d_rst_in_ready", i), 64'(in_ready[i]), 64'd1);
      check_eq($sformatf("u%0d_rst_out_valid", i), 64'(out_valid[i]), 64'd0);
      check_eq($sformatf("u%0d_rst_d", i), 64'(d_out[i]), 64'd0);
      check_eq($sformatf("u%0d_rst_bv", i), 64'({v_out[i], b_out[i]}), 64'd0);
      check_eq($sformatf("u%0d_rst_state", i), 64'(dbg[i]), 64'(ST_IDLE));
    end
    rst = 1'b0;

    // Directed vectors, CHUNK=8 (expected values written out by hand).
    do_op(1, 32'h0000_0005, 32'h0000_0003, 1'b0, {2'b00, 32'h0000_0002}, 0);
    do_op(1, 32'h0000_0000, 32'h0000_0001, 1'b0, {2'b01, 32'hFFFF_FFFF}, 0);
    do_op(1, 32'h8000_0000, 32'h0000_0001, 1'b0, {2'b10, 32'h7FFF_FFFF}, 0);
    do_op(1, 32'h0100_0000, 32'h0000_0001, 1'b1, {2'b00, 32'h00FF_FFFE}, 0);
    // Latency of the other chunk sizes.
    do_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0, {2'b00, 32'h0000_0002}, 0);
    do_op(2, 32'h0000_0000, 32'h0000_0001, 1'b0, {2'b01, 32'hFFFF_FFFF}, 0);

    // Backpressure: result held 10 cycles while new operands wait at the input.
    start(1, 32'h0000_0005, 32'h0000_0003, 1'b0, {2'b00, 32'h0000_0002});
    wait_valid(1);
    check_result(1);
    in_valid[1] = 1'b1;
    a[1] = 32'hAAAA_5555;
    b[1] = 32'h1111_1111;
    bin[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 64'(out_valid[1]), 64'd1);
      check_eq("bp_in_ready", 64'(in_ready[1]), 64'd0);
      check_eq("bp_d", 64'(d_out[1]), 64'h2);
      check_eq("bp_bv", 64'({v_out[1], b_out[1]}), 64'd0);
    end
    handoff(1);
    exp_q.push_back(model(32'hAAAA_5555, 32'h1111_1111, 1'b1));
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    check_eq("bp_accept_state", 64'(dbg[1]), 64'(ST_RUN));
    wait_valid(1);
    check_result(1);
    handoff(1);

    // Reset on the 2nd RUN cycle aborts the operation.
    start(1, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 34'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rstrun_state", 64'(dbg[1]), 64'(ST_IDLE));
    check_eq("rstrun_out_valid", 64'(out_valid[1]), 64'd0);
    check_eq("rstrun_in_ready", 64'(in_ready[1]), 64'd1);
    check_eq("rstrun_d", 64'(d_out[1]), 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    do_op(1, 32'h1234_5678, 32'h0234_5678, 1'b0, {2'b00, 32'h1000_0000}, 0);

    // Randomized operands on all three chunk sizes against the model.
    for (int n = 0; n < 1000; n++) begin
      u  = n % 3;
      av = $urandom;
      case ($urandom_range(0, 7))
        0:       bv = av;
        1:       bv = av + 32'd1;
        2:       bv = 32'h8000_0000;
        default: bv = $urandom;
      endcase
      bi = 1'($urandom_range(0, 1));
      do_op(u, av, bv, bi, model(av, bv, bi), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
